// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM state encoding,
// controller opcodes, instruction field positions and the legality rule
// used when ILLEGAL_FILTER_EN is defined.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } seq_state_e;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int OP_MSB     = 12;
    localparam int OP_LSB     = 11;

    localparam logic [2:0] OPCODE_MOV = 3'b110;
    localparam logic [2:0] OPCODE_ALU = 3'b101;

    // Instructions the controller implements: any ALU op, MOV with op 10 or 00.
    function automatic logic instr_legal(input logic [INSTR_W-1:0] instr);
        logic [2:0] opc;
        logic [1:0] op;
        opc = instr[OPCODE_MSB:OPCODE_LSB];
        op  = instr[OP_MSB:OP_LSB];
        return (opc == OPCODE_ALU) ||
               ((opc == OPCODE_MOV) && ((op == 2'b10) || (op == 2'b00)));
    endfunction

endpackage

// File: rtl/instr_sequencer_seq_fifo.sv
// Instruction FIFO: DEPTH entries (power of 2), head visible combinationally.
// A push is accepted only when not full, regardless of a same-cycle pop.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: buffers host instructions, issues them one at a time
// to the datapath controller over the s/w start handshake, counts retirements
// and traps a hung controller with a watchdog.
// Optional feature macro: ILLEGAL_FILTER_EN (discard instructions the
// controller does not implement instead of issuing them).
//
// Host handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready depends only on FIFO occupancy.
// Controller handshake: s_out is high for exactly the one S_ISSUE cycle; the
// instruction is complete when w_in is seen low and then high again.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    input  logic               pause,
    input  logic               w_in,
    output logic               s_out,
    output logic [15:0]        instr_out,
    output logic [2:0]         opcode_out,
    output logic [1:0]         op_out,
    output logic               busy,
    output logic               empty,
    output logic [CNT_W-1:0]   retired,
    output logic               fault,
    output logic               illegal_drop,
    output logic [1:0]         state_dbg
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1);

    seq_state_e         state, state_nx;
    logic [15:0]        ir, ir_nx;
    logic [WD_W-1:0]    wd_cnt, wd_nx;
    logic               seen_low, seen_low_nx;
    logic [CNT_W-1:0]   retired_q, retired_nx;
    logic               take;
    logic               fifo_pop;
    logic               fifo_full;
    logic [15:0]        fifo_head;
`ifdef ILLEGAL_FILTER_EN
    logic               drop_q, drop_nx;
`endif

    seq_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata (in_instr),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (empty)
    );

    assign in_ready   = !fifo_full;
    assign s_out      = (state == S_ISSUE);
    assign busy       = (state != S_IDLE);
    assign fault      = (state == S_FAULT);
    assign instr_out  = ir;
    assign opcode_out = ir[OPCODE_MSB:OPCODE_LSB];
    assign op_out     = ir[OP_MSB:OP_LSB];
    assign retired    = retired_q;
    assign state_dbg  = state;
`ifdef ILLEGAL_FILTER_EN
    assign illegal_drop = drop_q;
`else
    assign illegal_drop = 1'b0;
`endif

    // Next-state: issue decisions, completion detection, watchdog, pop/discard.
    always_comb begin
        state_nx    = state;
        ir_nx       = ir;
        wd_nx       = wd_cnt;
        seen_low_nx = seen_low;
        retired_nx  = retired_q;
        take        = 1'b0;
        fifo_pop    = 1'b0;
`ifdef ILLEGAL_FILTER_EN
        drop_nx     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                take = !empty && w_in && !pause;
            end
            S_ISSUE: begin
                state_nx    = S_EXEC;
                wd_nx       = '0;
                seen_low_nx = 1'b0;
            end
            S_EXEC: begin
                if (w_in && seen_low) begin
                    retired_nx = retired_q + RET_ONE;
                    state_nx   = S_IDLE;
                    take       = !empty && !pause;
                end else if (wd_cnt == WD_LAST) begin
                    state_nx = S_FAULT;
                end else begin
                    wd_nx = wd_cnt + WD_ONE;
                    if (!w_in) seen_low_nx = 1'b1;
                end
            end
            default: begin
                // S_FAULT holds until reset.
            end
        endcase

        if (take) begin
            fifo_pop = 1'b1;
`ifdef ILLEGAL_FILTER_EN
            if (instr_legal(fifo_head)) begin
                ir_nx    = fifo_head;
                state_nx = S_ISSUE;
            end else begin
                drop_nx  = 1'b1;
                state_nx = S_IDLE;
            end
`else
            ir_nx    = fifo_head;
            state_nx = S_ISSUE;
`endif
        end
    end

    // State, IR, watchdog and retirement registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ir        <= '0;
            wd_cnt    <= '0;
            seen_low  <= 1'b0;
            retired_q <= '0;
        end else begin
            state     <= state_nx;
            ir        <= ir_nx;
            wd_cnt    <= wd_nx;
            seen_low  <= seen_low_nx;
            retired_q <= retired_nx;
        end
    end

`ifdef ILLEGAL_FILTER_EN
    // One-cycle pulse for each discarded instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= 1'b0;
        else        drop_q <= drop_nx;
    end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed stimulus, a controller model driving
// w_in, a transaction-level reference model checked every cycle, and literal
// expectations for latency, ordering and boundary cases.
module tb_instr_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_instr = '0;
  logic             pause = 1'b0;
  logic             w_in = 1'b1;
  logic             in_ready;
  logic             s_out;
  logic [15:0]      instr_out;
  logic [2:0]       opcode_out;
  logic [1:0]       op_out;
  logic             busy;
  logic             empty;
  logic [CNT_W-1:0] retired;
  logic             fault;
  logic             illegal_drop;
  logic [1:0]       state_dbg;

  instr_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .pause        (pause),
    .w_in         (w_in),
    .s_out        (s_out),
    .instr_out    (instr_out),
    .opcode_out   (opcode_out),
    .op_out       (op_out),
    .busy         (busy),
    .empty        (empty),
    .retired      (retired),
    .fault        (fault),
    .illegal_drop (illegal_drop),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // ---------------- controller model ----------------
  // Answers s with w low for exec_len cycles; ignores instructions it does not implement.
  int ctl_cnt  = 0;
  int exec_len = 2;

  function automatic bit ctl_knows(input logic [15:0] i);
    return (i[15:13] == 3'b101) ||
           ((i[15:13] == 3'b110) && ((i[12:11] == 2'b10) || (i[12:11] == 2'b00)));
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      ctl_cnt = 0;
      w_in    = 1'b1;
    end else begin
      if (ctl_cnt > 0) begin
        w_in = 1'b0;
        ctl_cnt--;
      end else begin
        w_in = 1'b1;
      end
      if (s_out && ctl_knows(instr_out)) ctl_cnt = exec_len;
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_legal(input logic [15:0] i);
`ifdef ILLEGAL_FILTER_EN
    return ctl_knows(i);
`else
    return (i === i);
`endif
  endfunction

  logic [15:0]      mq[$];
  logic [15:0]      m_ir = '0;
  logic [CNT_W-1:0] m_ret = '0;
  bit               m_issue = 0;
  bit               m_fault = 0;
  bit               m_seen_low = 0;
  bit               m_drop = 0;
  int               m_age = -1;   // cycles spent executing, -1 when not executing

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ir = '0; m_ret = '0; m_issue = 0; m_fault = 0;
      m_seen_low = 0; m_drop = 0; m_age = -1;
    end else begin
      bit full_pre;
      bit take;
      logic [15:0] h;
      full_pre = (mq.size() == DEPTH);
      take     = 0;
      m_drop   = 0;
      if (m_fault) begin
        take = 0;
      end else if (m_issue) begin
        m_issue = 0; m_age = 0; m_seen_low = 0;
      end else if (m_age >= 0) begin
        if (w_in && m_seen_low) begin
          m_ret++;
          m_age = -1;
          take  = (mq.size() > 0) && !pause;
        end else if (m_age + 1 == TIMEOUT) begin
          m_fault = 1;
          m_age   = -1;
        end else begin
          m_age++;
          if (!w_in) m_seen_low = 1;
        end
      end else begin
        take = (mq.size() > 0) && w_in && !pause;
      end
      if (take) begin
        h = mq.pop_front();
        if (model_legal(h)) begin
          m_ir = h;
          m_issue = 1;
        end else begin
          m_drop = 1;
        end
      end
      if (in_valid && !full_pre) mq.push_back(in_instr);
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] issued_q[$];
  int          s_edge_q[$];
  int          ret_edge_q[$];
  int          n_drop = 0;
  logic [CNT_W-1:0] last_ret = '0;

  always @(posedge clk) begin
    #2;
    check("s_out",        32'(s_out),        32'(m_issue));
    check("busy",         32'(busy),         32'(m_issue || (m_age >= 0) || m_fault));
    check("fault",        32'(fault),        32'(m_fault));
    check("empty",        32'(empty),        32'(mq.size() == 0));
    check("in_ready",     32'(in_ready),     32'(mq.size() < DEPTH));
    check("instr_out",    32'(instr_out),    32'(m_ir));
    check("opcode_out",   32'(opcode_out),   32'(m_ir[15:13]));
    check("op_out",       32'(op_out),       32'(m_ir[12:11]));
    check("retired",      32'(retired),      32'(m_ret));
    check("illegal_drop", 32'(illegal_drop), 32'(m_drop));
    if (s_out) begin
      issued_q.push_back(instr_out);
      s_edge_q.push_back(edge_n);
    end
    if (retired != last_ret) ret_edge_q.push_back(edge_n);
    last_ret = retired;
    if (illegal_drop) n_drop++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    issued_q.delete();
    s_edge_q.delete();
    ret_edge_q.delete();
    n_drop = 0;
  endtask

  task automatic push(input logic [15:0] v, output int at_edge);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = v;
    @(posedge clk);
    #1;
    at_edge = edge_n;
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_retired(input logic [CNT_W-1:0] target, input int budget, input string name);
    int k = 0;
    while (retired !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(retired), 32'(target));
  endtask

  task automatic wait_fault(input int budget);
    int k = 0;
    while (fault !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // ---------------- directed tests ----------------
  logic [15:0] exp_order[4];

  initial begin
    int e0, e1;
    int k;

    // Reset values while reset is held low.
    #12;
    check("rst_s_out",   32'(s_out),     32'd0);
    check("rst_busy",    32'(busy),      32'd0);
    check("rst_empty",   32'(empty),     32'd1);
    check("rst_ready",   32'(in_ready),  32'd1);
    check("rst_retired", 32'(retired),   32'd0);
    check("rst_fault",   32'(fault),     32'd0);
    check("rst_ir",      32'(instr_out), 32'h0);
    check("rst_drop",    32'(illegal_drop), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1. MOV-immediate latency and single start pulse.
    exec_len = 2;
    clear_logs();
    push(16'hD005, e0);
    release_in();
    wait_retired(8'd1, 30, "t1_retire");
    check("t1_s_count", 32'(s_edge_q.size()), 32'd1);
    if (s_edge_q.size() > 0) check("t1_s_edge", 32'(s_edge_q[0]), 32'(e0 + 1));
    if (ret_edge_q.size() > 0) check("t1_ret_edge", 32'(ret_edge_q[0]), 32'(e0 + 5));
    check("t1_ir", 32'(instr_out), 32'hD005);
    check("t1_opcode", 32'(opcode_out), 32'h6);
    check("t1_op", 32'(op_out), 32'h2);
    @(negedge clk);
    check("t1_idle", 32'(busy), 32'd0);

    // 2. Back-to-back ADD then CMP.
    clear_logs();
    push(16'hA000, e0);
    push(16'hA800, e1);
    release_in();
    wait_retired(8'd3, 40, "t2_retire");
    check("t2_s_count", 32'(s_edge_q.size()), 32'd2);
    if (s_edge_q.size() == 2) begin
      check("t2_gap", 32'(s_edge_q[1] - s_edge_q[0]), 32'd4);
      check("t2_first_s", 32'(s_edge_q[0]), 32'(e0 + 1));
      check("t2_second_ir", 32'(issued_q[1]), 32'hA800);
    end
    if (ret_edge_q.size() > 0 && s_edge_q.size() == 2)
      check("t2_no_idle", 32'(s_edge_q[1]), 32'(ret_edge_q[0]));

    // 3. Full FIFO under pause, fifth push refused, then drain in order.
    clear_logs();
    @(negedge clk);
    pause = 1'b1;
    push(16'hA001, e0);
    push(16'hA802, e0);
    push(16'hD003, e0);
    check("t3_ready_3", 32'(in_ready), 32'd1);
    push(16'hA004, e0);
    check("t3_ready_4", 32'(in_ready), 32'd0);
    push(16'hA805, e0);
    check("t3_ready_5", 32'(in_ready), 32'd0);
    release_in();
    check("t3_no_issue", 32'(s_edge_q.size()), 32'd0);
    @(negedge clk);
    pause = 1'b0;
    wait_retired(8'd7, 200, "t3_retire");
    exp_order[0] = 16'hA001;
    exp_order[1] = 16'hA802;
    exp_order[2] = 16'hD003;
    exp_order[3] = 16'hA004;
    check("t3_count", 32'(issued_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < issued_q.size()) check("t3_order", 32'(issued_q[i]), 32'(exp_order[i]));
    repeat (3) @(negedge clk);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_retired", 32'(retired), 32'd7);

    // 5. Reset mid-instruction with a non-empty FIFO.
    clear_logs();
    push(16'hA000, e0);
    push(16'hA800, e0);
    push(16'hD005, e0);
    release_in();
    k = 0;
    while (!s_out && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("t5_issued", 32'(s_out), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("t5_retired", 32'(retired), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ir", 32'(instr_out), 32'h0);
    check("t5_s_out", 32'(s_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // 4. Hung controller: watchdog trips, no further issue, pushes still taken.
    exec_len = 1000;
    clear_logs();
    push(16'hA000, e0);
    release_in();
    wait_fault(60);
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_edge", 32'(edge_n), 32'(e0 + 17));
    push(16'hA800, e1);
    release_in();
    check("t4_push_taken", 32'(empty), 32'd0);
    repeat (10) @(negedge clk);
    check("t4_s_count", 32'(s_edge_q.size()), 32'd1);
    check("t4_fault_held", 32'(fault), 32'd1);
    check("t4_retired", 32'(retired), 32'd0);

    // 6. Illegal instruction followed by MOV.
    do_reset();
    exec_len = 2;
    clear_logs();
    push(16'h0000, e0);
    push(16'hD005, e1);
    release_in();
`ifdef ILLEGAL_FILTER_EN
    wait_retired(8'd1, 40, "t6_retire");
    repeat (2) @(negedge clk);
    check("t6_drops", 32'(n_drop), 32'd1);
    check("t6_s_count", 32'(s_edge_q.size()), 32'd1);
    if (issued_q.size() > 0) check("t6_ir", 32'(issued_q[0]), 32'hD005);
    check("t6_fault", 32'(fault), 32'd0);
`else
    wait_fault(60);
    check("t6_fault", 32'(fault), 32'd1);
    check("t6_fault_edge", 32'(edge_n), 32'(e0 + 17));
    if (issued_q.size() > 0) check("t6_ir", 32'(issued_q[0]), 32'h0000);
    check("t6_retired", 32'(retired), 32'd0);
    check("t6_drops", 32'(n_drop), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: got stalled expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Issuing end of the s/w start-handshake that the datapath FSM controller answers.
- Buffers 16-bit instructions from a host in a small FIFO.
- Presents one instruction at a time (opcode, op, full word) to the controller, pulses s, and holds the instruction stable until the controller's w returns high.
- Counts retired instructions and flags a hung controller with a watchdog.

Parameters:
DEPTH, 4, FIFO entries (power of 2, at least 2)
TIMEOUT, 15, max cycles in S_EXEC before fault
CNT_W, 8, width of retired counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (asserted at 0)
in_valid  in  1  host offers in_instr
in_instr  in  16  instruction; [15:13] opcode, [12:11] op
in_ready  out  1  FIFO not full
pause  in  1  inhibit new issues
w_in  in  1  controller w (high = controller in WAIT)
s_out  out  1  start pulse to controller
instr_out  out  16  held instruction register (IR)
opcode_out  out  3  IR[15:13]
op_out  out  2  IR[12:11]
busy  out  1  state is not S_IDLE
empty  out  1  FIFO empty
retired  out  CNT_W  completed-instruction count, wraps
fault  out  1  sticky watchdog error
illegal_drop  out  1  one-cycle pulse when an instruction is discarded (feature only)

Behaviour:
- Reset (reset=0, async):
  - State S_IDLE; FIFO empty; IR=0.
  - s_out=0, retired=0, fault=0, illegal_drop=0, busy=0, empty=1, in_ready=1.
- FIFO:
  - Push when in_valid & in_ready. in_ready = !full; a push is refused when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, pointers both advance and wrap modulo DEPTH.
- State S_IDLE:
  - If !empty & w_in & !pause & !fault: pop the head into IR and go to S_ISSUE.
  - Otherwise stay.
- State S_ISSUE: s_out=1 for exactly this cycle; go to S_EXEC; clear seen_low and the watchdog counter.
- State S_EXEC:
  - s_out=0.
  - Set seen_low when w_in=0.
  - Completion is w_in=1 with seen_low=1. On completion, retired+1.
  - After completion: if !empty & !pause, pop into IR and go to S_ISSUE (back-to-back); else go to S_IDLE.
  - w_in=1 on the first S_EXEC cycle is not completion.
- Watchdog:
  - Counter increments every cycle in S_EXEC.
  - When it reaches TIMEOUT without completion, go to S_FAULT.
- State S_FAULT:
  - fault=1, s_out=0; no issue; FIFO still accepts pushes.
  - Exit only by reset.
- IR and opcode_out/op_out change only on a pop; they are stable from S_ISSUE through completion.
- pause:
  - Checked only at issue decisions.
  - Never aborts an instruction in flight.
- Reset mid-instruction: immediate return to reset values; FIFO contents discarded.
- Latency:
  - A push at edge N into an empty, idle sequencer with w_in=1 gives s_out=1 during cycle N+2.
  - MOV-immediate retires at edge N+5.

Optional Feature:
Macro ILLEGAL_FILTER_EN.
- Defined:
  - On pop, an instruction is legal only if opcode=110 with op in {10,00}, or opcode=101 with any op.
  - An illegal instruction is discarded instead of entering IR. illegal_drop pulses for 1 cycle; IR is unchanged; state stays or returns to S_IDLE; retired is unchanged.
  - At most one discard per cycle.
- Not defined: every instruction is issued, an illegal one trips the watchdog, and illegal_drop is tied 0.

Decomposition:
- Shared package: state encodings (S_IDLE, S_ISSUE, S_EXEC, S_FAULT), OPCODE_MOV=3'b110, OPCODE_ALU=3'b101, and the instruction field bit positions.
- One sub-module, seq_fifo: parameterised storage, pointers, count, full/empty.
- FSM, watchdog and counter stay in the top level.

Test Plan:
1. MOV-immediate: push 16'hD005 (opcode 110, op 10) with the controller model in WAIT -> s_out high for exactly one cycle, instr_out=16'hD005 held stable, retired 0->1, busy returns to 0.
2. Back-to-back: push ADD 16'hA000 then CMP 16'hA800 -> second s_out occurs the cycle after the first completion, retired=2, no idle cycle between.
3. Full FIFO: push 5 instructions while pause=1 with DEPTH=4 -> in_ready=0 after the 4th push and the 5th is refused. Release pause -> exactly 4 retire, in order.
4. Hung controller: w_in forced 0 after s_out -> fault=1 when the watchdog reaches 15; no further s_out; pushes still accepted.
5. Reset mid-instruction: assert reset=0 during S_EXEC of ADD -> asynchronous return to reset values; retired=0, empty=1.
6. Filter (ILLEGAL_FILTER_EN): push 16'h0000 then 16'hD005 -> illegal_drop pulses once, only 16'hD005 issues, retired=1. Without the macro, the same stimulus -> fault=1.
